// File: rtl/ravenoc_vc_buffer.sv
// Multi-VC input buffer for one RaveNoC router port: per-VC FIFOs feeding a
// packet-locking output arbiter (round-robin or fixed priority).
module ravenoc_vc_buffer #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 3,
    parameter int BUFF_DEPTH = 4,
    parameter int ARB_MODE   = 0,
    parameter int LOCK_PKT   = 1,
    localparam int VC_W      = $clog2(N_VIRT_CHN > 1 ? N_VIRT_CHN : 2)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [FLIT_WIDTH-1:0] flit_data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [VC_W-1:0]       vc_id_i,
    output logic [FLIT_WIDTH-1:0] flit_data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [VC_W-1:0]       vc_id_o,
    output logic [N_VIRT_CHN-1:0] full_o,
    output logic [N_VIRT_CHN-1:0] empty_o,
    output logic                  drop_o
);
    localparam int PTR_W = $clog2(BUFF_DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    logic [FLIT_WIDTH-1:0] mem_q    [N_VIRT_CHN][BUFF_DEPTH];
    logic [FLIT_WIDTH-1:0] mem_d    [N_VIRT_CHN][BUFF_DEPTH];
    logic [PTR_W:0]        wr_ptr_q [N_VIRT_CHN];
    logic [PTR_W:0]        wr_ptr_d [N_VIRT_CHN];
    logic [PTR_W:0]        rd_ptr_q [N_VIRT_CHN];
    logic [PTR_W:0]        rd_ptr_d [N_VIRT_CHN];
    arb_state_t            state_q, state_d;
    logic [VC_W-1:0]       grant_q, grant_d;
    logic [VC_W-1:0]       rr_last_q, rr_last_d;
    logic                  drop_q, drop_d;

    logic                  vc_legal_s;
    logic                  full_sel_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic                  any_req_s;
    logic                  grant_empty_s;
    logic [FLIT_WIDTH-1:0] head_s;
    logic [VC_W-1:0]       pick_s;

    // Per-VC full/empty from wrap-bit pointers
    always_comb begin
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            empty_o[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
            full_o[v]  = (wr_ptr_q[v][PTR_W-1:0] == rd_ptr_q[v][PTR_W-1:0]) &&
                         (wr_ptr_q[v][PTR_W] != rd_ptr_q[v][PTR_W]);
        end
    end

    // Input acceptance; an illegal VC is always accepted and then dropped
    always_comb begin
        vc_legal_s = (int'(vc_id_i) < N_VIRT_CHN);
        full_sel_s = 1'b0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            full_sel_s = full_sel_s | (full_o[v] & (vc_id_i == VC_W'(v)));
        end
        ready_o = ~full_sel_s;
        wr_en_s = valid_i & ready_o & vc_legal_s;
        drop_d  = valid_i & ~vc_legal_s;
    end

    // Output side: head of the granted FIFO, zeroed when not valid
    always_comb begin
        head_s        = {FLIT_WIDTH{1'b0}};
        grant_empty_s = 1'b1;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            head_s        = (grant_q == VC_W'(v)) ? mem_q[v][rd_ptr_q[v][PTR_W-1:0]] : head_s;
            grant_empty_s = (grant_q == VC_W'(v)) ? empty_o[v] : grant_empty_s;
        end
        valid_o     = (state_q == ST_LOCKED) & ~grant_empty_s;
        flit_data_o = valid_o ? head_s : {FLIT_WIDTH{1'b0}};
        vc_id_o     = grant_q;
        rd_en_s     = valid_o & ready_i;
        drop_o      = drop_q;
    end

    // FIFO storage and pointer updates
    always_comb begin
        mem_d = mem_q;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (wr_en_s && (vc_id_i == VC_W'(v))) begin
                mem_d[v][wr_ptr_q[v][PTR_W-1:0]] = flit_data_i;
                wr_ptr_d[v] = wr_ptr_q[v] + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d[v] = wr_ptr_q[v];
            end
            if (rd_en_s && (grant_q == VC_W'(v))) begin
                rd_ptr_d[v] = rd_ptr_q[v] + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d[v] = rd_ptr_q[v];
            end
        end
    end

    // Arbitration pick; later assignments win, so scan order is lowest priority first
    always_comb begin
        any_req_s = ~&empty_o;
        pick_s    = rr_last_q;
        if (ARB_MODE == 1) begin
            for (int v = 0; v < N_VIRT_CHN; v++) begin
                pick_s = empty_o[v] ? pick_s : VC_W'(v);
            end
        end else begin
            for (int k = N_VIRT_CHN; k >= 1; k--) begin
                pick_s = empty_o[(int'(rr_last_q) + k) % N_VIRT_CHN] ? pick_s :
                         VC_W'((int'(rr_last_q) + k) % N_VIRT_CHN);
            end
        end
    end

    // Arbiter FSM next state; the MSB of the type field marks tail / head_tail
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_d   = pick_s;
                    rr_last_d = pick_s;
                    state_d   = ST_LOCKED;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (rd_en_s && ((LOCK_PKT == 0) || head_s[FLIT_WIDTH-1])) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and pointer registers
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int v = 0; v < N_VIRT_CHN; v++) begin
                wr_ptr_q[v] <= {(PTR_W+1){1'b0}};
                rd_ptr_q[v] <= {(PTR_W+1){1'b0}};
            end
            state_q   <= ST_IDLE;
            grant_q   <= {VC_W{1'b0}};
            rr_last_q <= VC_W'(N_VIRT_CHN - 1);
            drop_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            drop_q    <= drop_d;
        end
    end

    // Flit storage needs no reset: contents are only visible behind valid pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_ravenoc_vc_buffer.sv
// Bench for ravenoc_vc_buffer: a round-robin and a fixed-priority instance share
// the same stimulus and are each compared against a queue-based packet model.
module tb_ravenoc_vc_buffer;
    localparam int FW = 34;
    localparam int NV = 3;
    localparam int BD = 4;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic [FW-1:0] flit_data_i = '0;
    logic          valid_i = 1'b0;
    logic [VW-1:0] vc_id_i = '0;
    logic          ready_i = 1'b0;

    logic [1:0]    ready_o_s;
    logic [1:0]    valid_o_s;
    logic [1:0]    drop_o_s;
    logic [FW-1:0] flit_o_s  [2];
    logic [VW-1:0] vc_o_s    [2];
    logic [NV-1:0] full_o_s  [2];
    logic [NV-1:0] empty_o_s [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: per instance (index m*NV+vc) a queue of buffered flits
    logic [FW-1:0] mq [2*NV][$];
    bit            locked   [2];
    int            grant    [2];
    int            rr_last  [2];
    bit            drop_exp [2];
    int            log_vc   [2][$];
    int            log_cy   [2][$];
    logic [FW-1:0] log_fl   [2][$];

    always #5 clk = ~clk;

    ravenoc_vc_buffer #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV), .BUFF_DEPTH(BD),
                        .ARB_MODE(0), .LOCK_PKT(1)) u_dut_rr (
        .clk(clk), .arst(arst), .flit_data_i(flit_data_i), .valid_i(valid_i),
        .ready_o(ready_o_s[0]), .vc_id_i(vc_id_i), .flit_data_o(flit_o_s[0]),
        .valid_o(valid_o_s[0]), .ready_i(ready_i), .vc_id_o(vc_o_s[0]),
        .full_o(full_o_s[0]), .empty_o(empty_o_s[0]), .drop_o(drop_o_s[0]));

    ravenoc_vc_buffer #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV), .BUFF_DEPTH(BD),
                        .ARB_MODE(1), .LOCK_PKT(1)) u_dut_fp (
        .clk(clk), .arst(arst), .flit_data_i(flit_data_i), .valid_i(valid_i),
        .ready_o(ready_o_s[1]), .vc_id_o(vc_o_s[1]), .vc_id_i(vc_id_i),
        .flit_data_o(flit_o_s[1]), .valid_o(valid_o_s[1]), .ready_i(ready_i),
        .full_o(full_o_s[1]), .empty_o(empty_o_s[1]), .drop_o(drop_o_s[1]));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2*NV; i++) mq[i].delete();
        for (int m = 0; m < 2; m++) begin
            locked[m]   = 1'b0;
            grant[m]    = 0;
            rr_last[m]  = NV - 1;
            drop_exp[m] = 1'b0;
        end
    endtask

    task automatic compare_all();
        int            gi;
        bit            ev;
        bit            er;
        logic [FW-1:0] ed;
        logic [NV-1:0] ef;
        logic [NV-1:0] ee;
        for (int m = 0; m < 2; m++) begin
            gi = m*NV + grant[m];
            ev = locked[m] && (mq[gi].size() > 0);
            ed = ev ? mq[gi][0] : '0;
            er = (int'(vc_id_i) >= NV) ? 1'b1 : (mq[m*NV + int'(vc_id_i)].size() < BD);
            for (int v = 0; v < NV; v++) begin
                ef[v] = (mq[m*NV+v].size() == BD);
                ee[v] = (mq[m*NV+v].size() == 0);
            end
            check_val($sformatf("i%0d_ready", m), ready_o_s[m], er);
            check_val($sformatf("i%0d_valid", m), valid_o_s[m], ev);
            check_val($sformatf("i%0d_data", m), flit_o_s[m], ed);
            check_val($sformatf("i%0d_full", m), full_o_s[m], ef);
            check_val($sformatf("i%0d_empty", m), empty_o_s[m], ee);
            check_val($sformatf("i%0d_drop", m), drop_o_s[m], drop_exp[m]);
            if (ev) check_val($sformatf("i%0d_vc", m), vc_o_s[m], grant[m]);
            if (valid_o_s[m] && ready_i && arst) begin
                log_vc[m].push_back(int'(vc_o_s[m]));
                log_cy[m].push_back(cyc);
                log_fl[m].push_back(flit_o_s[m]);
            end
        end
    endtask

    // Advance the model across one rising edge using the currently driven inputs
    task automatic update_model();
        bit            legal;
        bit            rdy_exp;
        bit            ev;
        int            pick;
        int            v;
        logic [FW-1:0] f;
        for (int m = 0; m < 2; m++) begin
            legal       = (int'(vc_id_i) < NV);
            rdy_exp     = legal ? (mq[m*NV + int'(vc_id_i)].size() < BD) : 1'b1;
            drop_exp[m] = valid_i && !legal;
            ev          = locked[m] && (mq[m*NV + grant[m]].size() > 0);
            if (locked[m]) begin
                if (ev && ready_i) begin
                    f = mq[m*NV + grant[m]].pop_front();
                    if (f[FW-1:FW-2] == 2'b10 || f[FW-1:FW-2] == 2'b11) locked[m] = 1'b0;
                end
            end else begin
                pick = -1;
                for (int k = 0; k < NV; k++) begin
                    v = (m == 1) ? (NV - 1 - k) : ((rr_last[m] + 1 + k) % NV);
                    if (pick < 0 && mq[m*NV+v].size() > 0) pick = v;
                end
                if (pick >= 0) begin
                    grant[m]   = pick;
                    rr_last[m] = pick;
                    locked[m]  = 1'b1;
                end
            end
            if (valid_i && rdy_exp && legal) mq[m*NV + int'(vc_id_i)].push_back(flit_data_i);
        end
    endtask

    task automatic step(input logic vin, input logic [VW-1:0] vc, input logic [FW-1:0] d,
                        input logic rdy);
        @(negedge clk);
        valid_i     = vin;
        vc_id_i     = vc;
        flit_data_i = d;
        ready_i     = rdy;
        #1;
        compare_all();
        update_model();
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst    = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        vc_id_i = '0;
        #1;
        model_reset();
        compare_all();
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("rst_valid%0d", m), valid_o_s[m], 1'b0);
            check_val($sformatf("rst_data%0d", m), flit_o_s[m], 34'h0);
            check_val($sformatf("rst_empty%0d", m), empty_o_s[m], 3'b111);
            check_val($sformatf("rst_vc%0d", m), vc_o_s[m], 2'd0);
            check_val($sformatf("rst_ready%0d", m), ready_o_s[m], 1'b1);
        end
        @(negedge clk);
        #1;
        compare_all();
        arst = 1'b1;
    endtask

    task automatic clear_logs();
        for (int m = 0; m < 2; m++) begin
            log_vc[m].delete();
            log_cy[m].delete();
            log_fl[m].delete();
        end
    endtask

    initial begin
        logic [FW-1:0] rd;
        do_reset();

        // Single head_tail flit on VC1
        step(1'b1, 2'd1, 34'h3_0000_00AA, 1'b0);
        step(1'b0, 2'd0, 34'h0, 1'b0);
        check_val("t2_valid_c1", valid_o_s[0], 1'b0);
        step(1'b0, 2'd0, 34'h0, 1'b1);
        check_val("t2_valid_c2", valid_o_s[0], 1'b1);
        check_val("t2_vc_c2", vc_o_s[0], 2'd1);
        check_val("t2_data_c2", flit_o_s[1], 34'h3_0000_00AA);
        step(1'b0, 2'd0, 34'h0, 1'b0);
        check_val("t2_empty", empty_o_s[0][1], 1'b1);
        check_val("t2_idle", valid_o_s[1], 1'b0);

        // Fill VC0 under backpressure, then probe ready, stability and an illegal VC
        do_reset();
        step(1'b1, 2'd0, 34'h0_0000_00A0, 1'b0);
        step(1'b1, 2'd0, 34'h1_0000_00A1, 1'b0);
        step(1'b1, 2'd0, 34'h1_0000_00A2, 1'b0);
        step(1'b1, 2'd0, 34'h2_0000_00A3, 1'b0);
        step(1'b1, 2'd0, 34'h0_0000_00FF, 1'b0);
        check_val("t3_full", full_o_s[0], 3'b001);
        check_val("t3_ready_vc0", ready_o_s[1], 1'b0);
        step(1'b0, 2'd2, 34'h0, 1'b0);
        check_val("t3_ready_vc2", ready_o_s[0], 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'd0, 34'h0, 1'b0);
            check_val("t6_stable", flit_o_s[0], 34'h0_0000_00A0);
        end
        step(1'b1, 2'd3, 34'h0_0000_1234, 1'b0);
        step(1'b0, 2'd0, 34'h0, 1'b0);
        check_val("t6_drop", drop_o_s[0], 1'b1);
        step(1'b0, 2'd0, 34'h0, 1'b0);
        check_val("t6_drop_end", drop_o_s[1], 1'b0);
        check_val("t6_nochange", empty_o_s[0], 3'b110);
        clear_logs();
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 34'h0, 1'b1);
        check_val("t3_drained", log_fl[0].size(), 4);

        // Packet locking with fixed priority: VC1 stalls while VC0 and VC2 queue
        do_reset();
        step(1'b1, 2'd1, 34'h3_0000_0011, 1'b0);
        step(1'b1, 2'd0, 34'h0_0000_00B0, 1'b0);
        step(1'b1, 2'd0, 34'h1_0000_00B1, 1'b0);
        step(1'b1, 2'd0, 34'h2_0000_00B2, 1'b0);
        step(1'b1, 2'd2, 34'h3_0000_0022, 1'b0);
        clear_logs();
        for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 34'h0, 1'b1);
        check_val("t4_count", log_vc[1].size(), 5);
        if (log_vc[1].size() == 5) begin
            check_val("t4_first_vc1", log_vc[1][0], 1);
            check_val("t4_vc2_before_vc0", log_vc[1][1], 2);
            check_val("t4_head", log_fl[1][2], 34'h0_0000_00B0);
            check_val("t4_body", log_fl[1][3], 34'h1_0000_00B1);
            check_val("t4_tail", log_fl[1][4], 34'h2_0000_00B2);
            check_val("t4_consec1", log_cy[1][3] - log_cy[1][2], 1);
            check_val("t4_consec2", log_cy[1][4] - log_cy[1][3], 1);
            check_val("t4_bubble", log_cy[1][1] - log_cy[1][0], 2);
        end

        // Round-robin over three single-flit packets
        do_reset();
        step(1'b1, 2'd0, 34'h3_0000_0C00, 1'b0);
        step(1'b1, 2'd1, 34'h3_0000_0C01, 1'b0);
        step(1'b1, 2'd2, 34'h3_0000_0C02, 1'b0);
        clear_logs();
        for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 34'h0, 1'b1);
        check_val("t5_count", log_vc[0].size(), 3);
        if (log_vc[0].size() == 3) begin
            for (int i = 0; i < 3; i++) check_val($sformatf("t5_order%0d", i), log_vc[0][i], i);
            check_val("t5_gap01", log_cy[0][1] - log_cy[0][0], 2);
            check_val("t5_gap12", log_cy[0][2] - log_cy[0][1], 2);
        end

        // Random traffic with a mid-run reset
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            rd = {2'($urandom_range(0, 3)), 32'($urandom())};
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                 rd, ($urandom_range(0, 9) < 6));
        end
        clear_logs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
